imem_program_loader: RTL and testbench
======================================

// Module: imem_program_loader
// PURPOSE
//  Encoder side of the control decoder: accepts instruction fields (kind, rd, rs1, rs2, imm) over valid/ready,
//  packs them into RV32I words (LW, SW, ADD, AND, OR, BEQ, JAL) and writes them to instruction memory at sequential
//  word addresses. Holds the single-cycle core in reset while loading. Used by FPGA boot and testbench program load.
// PARAMETERS
//  ADDR_W   5    imem word-address width
//  DEPTH    32   imem capacity in words (<= 2**ADDR_W)
// PORTS
//  clk        in   1       rising-edge clock; the block's only clock
//  rst        in   1       reset; synchronous, active-high
//  start      in   1       1-cycle pulse; begins a load session (ignored unless IDLE or DONE)
//  in_valid   in   1       field beat valid
//  in_ready   out  1       block accepts a beat this cycle
//  in_kind    in   3       kind_e: 0 LW, 1 SW, 2 ADD, 3 AND, 4 OR, 5 BEQ, 6 JAL, 7 reserved
//  in_rd      in   5       destination reg
//  in_rs1     in   5       source reg 1
//  in_rs2     in   5       source reg 2
//  in_imm     in   21      signed immediate (byte offset for BEQ/JAL)
//  in_last    in   1       marks final beat of program
//  imem_we    out  1       imem write strobe
//  imem_addr  out  ADDR_W  imem word address
//  imem_wdata out  32      encoded instruction
//  cpu_hold   out  1       keep core in reset / fetch stalled
//  done       out  1       load complete (level, until next start)
//  count      out  ADDR_W+1 words written this session
//  err        out  1       sticky: illegal kind or overflow this session
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, count=0, err=0.
//  FSM IDLE --start--> LOAD (count=0, err=0, done=0, cpu_hold=1); DONE --start--> LOAD (same clears).
//  LOAD: in_ready=1 while count<DEPTH. Handshake = in_valid&in_ready; fields need only be stable in that cycle.
//  Latency 1: beat accepted at cycle t -> imem_we=1, imem_addr=count(t), imem_wdata=encode at t+1; count++ at t+1.
//  imem_we low in every cycle without an accepted beat in the previous cycle; no bubbles required between beats.
//  Accepted beat with in_last=1 -> LOAD->DONE at t+1 (same edge as the write); done=1, cpu_hold=0 from t+1.
//  Overflow: count==DEPTH in LOAD -> in_ready=0; a pending in_valid sets err=1 and goes DONE (beat dropped).
//  Encoding: LW {imm[11:0],rs1,010,rd,0000011}; SW {imm[11:5],rs2,rs1,010,imm[4:0],0100011};
//   ADD/AND/OR {0000000,rs2,rs1,f3(000/111/110),rd,0110011}; BEQ {imm[12],imm[10:5],rs2,rs1,000,imm[4:1],imm[11],1100011};
//   JAL {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}. Unused fields ignored; imm bits above range truncated.
//  Kind 7: writes NOP 32'h00000013, sets err=1, load continues.
//  start while in LOAD: ignored. rst mid-load: immediate return to reset values; partial imem contents are not cleared.
// CONFIGURATION
//  IMEM_RANGE_CHECK_EN defined: err=1 also when imm does not sign-fit its field (LW/SW 12b, BEQ 13b, JAL 21b) or
//   BEQ/JAL imm[0]=1; the truncated word is still written. Undefined: no range check; silent truncation.
// STRUCTURE
//  rv_encode_pkg: kind_e enum, OP_LOAD/OP_STORE/OP_RTYPE/OP_BRANCH/OP_JAL opcodes, F3_* constants,
//   NOP_WORD, state_e {IDLE, LOAD, DONE}.
//  Sub-module rv_instr_encoder: purely combinational fields->word (+illegal and range-error flags); the top holds
//   the FSM, counter, output register and handshake.
// TESTING
//  ADD x3,x1,x2 then AND, OR, each in_last=0, then LW x5,8(x1) last -> addrs 0..3; word0=0x002081B3,
//   word3=0x0080A283; done=1, count=4.
//  SW x2,12(x1) -> 0x0020A623; BEQ x0,x0,imm=-4 -> 0xFE000EE3; JAL x1,0 last -> 0x000000EF.
//  Back-to-back valid for 3 cycles -> imem_we high 3 consecutive cycles, each 1 cycle after acceptance.
//  DEPTH=4, 5 beats -> 4 writes; in_ready=0 after 4th; err=1, DONE, 5th dropped.
//  kind=7 -> NOP 0x00000013 written, err=1; rst mid-load -> all outputs to reset values next cycle.
//  With IMEM_RANGE_CHECK_EN: BEQ imm=5 -> err=1; LW imm=2048 -> err=1. Without: err stays 0.

Source files
------------

// File: rtl/rv_encode_pkg.sv
// Shared encoder types: instruction kinds, RV32I opcode/funct3 constants, loader FSM states.
// Also holds the signed-fit helper used by the optional immediate range check.
package rv_encode_pkg;

    typedef enum logic [2:0] {
        K_LW   = 3'd0,
        K_SW   = 3'd1,
        K_ADD  = 3'd2,
        K_AND  = 3'd3,
        K_OR   = 3'd4,
        K_BEQ  = 3'd5,
        K_JAL  = 3'd6,
        K_RSVD = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // True when imm[20:w-1] is all zeros or all ones, i.e. the value sign-fits w bits.
    function automatic logic sign_fits(input logic [20:0] imm, input int w);
        logic [20:0] hi_mask;
        logic [20:0] hi_bits;
        hi_mask = ~((21'(1) << (w - 1)) - 21'(1));
        hi_bits = imm & hi_mask;
        return (hi_bits == 21'd0) || (hi_bits == hi_mask);
    endfunction

endpackage

// File: rtl/imem_program_loader_if.sv
// Loader bundle: instruction-field beats in, imem write port and load status out.
// master = host driving beats, slave = the loader itself.
interface imem_program_loader_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [20:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              err;

    modport master (
        output start, in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, count, err
    );

    modport slave (
        input  start, in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, count, err
    );
endinterface

// File: rtl/rv_instr_encoder.sv
// Combinational fields->RV32I word packer with illegal-kind flag; zero latency, no flow control.
// IMEM_RANGE_CHECK_EN enables the immediate fit/alignment error flag, otherwise imm is silently truncated.
module rv_instr_encoder
    import rv_encode_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [20:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        range_err_o
);

    always_comb begin
        word_o    = NOP_WORD;
        illegal_o = 1'b0;
        case (kind_e'(kind_i))
            K_LW:  word_o = {imm_i[11:0], rs1_i, F3_LW, rd_i, OP_LOAD};
            K_SW:  word_o = {imm_i[11:5], rs2_i, rs1_i, F3_SW, imm_i[4:0], OP_STORE};
            K_ADD: word_o = {7'b0000000, rs2_i, rs1_i, F3_ADD, rd_i, OP_RTYPE};
            K_AND: word_o = {7'b0000000, rs2_i, rs1_i, F3_AND, rd_i, OP_RTYPE};
            K_OR:  word_o = {7'b0000000, rs2_i, rs1_i, F3_OR, rd_i, OP_RTYPE};
            K_BEQ: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                             imm_i[4:1], imm_i[11], OP_BRANCH};
            K_JAL: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
            default: illegal_o = 1'b1;
        endcase
    end

`ifdef IMEM_RANGE_CHECK_EN
    // Branch/jump offsets are byte offsets, so bit 0 must be clear as well as fitting the field.
    always_comb begin
        range_err_o = 1'b0;
        case (kind_e'(kind_i))
            K_LW, K_SW: range_err_o = !sign_fits(imm_i, 12);
            K_BEQ:      range_err_o = !sign_fits(imm_i, 13) || imm_i[0];
            K_JAL:      range_err_o = imm_i[0];
            default:    range_err_o = 1'b0;
        endcase
    end
`else
    logic unused_imm0;
    assign unused_imm0 = imm_i[0];
    assign range_err_o = 1'b0;
`endif

endmodule

// File: rtl/imem_program_loader.sv
// Loads an encoded program into imem at sequential word addresses, holding the core while loading; 1-cycle write latency.
// in_ready only in LOAD with room left; a beat offered when full sets err and ends the session. Macro: IMEM_RANGE_CHECK_EN.
module imem_program_loader
    import rv_encode_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input logic                  clk,
    input logic                  rst,
    imem_program_loader_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;

    logic              in_ready, cpu_hold, done;
    logic              room, accept, session_start, overflow;
    logic [31:0]       enc_word;
    logic              enc_illegal, enc_range_err;

    rv_instr_encoder u_enc (
        .kind_i      (bus.in_kind),
        .rd_i        (bus.in_rd),
        .rs1_i       (bus.in_rs1),
        .rs2_i       (bus.in_rs2),
        .imm_i       (bus.in_imm),
        .word_o      (enc_word),
        .illegal_o   (enc_illegal),
        .range_err_o (enc_range_err)
    );

    assign room          = (count_q < DEPTH_C);
    assign accept        = bus.in_valid && in_ready;
    assign session_start = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign overflow      = (state_q == LOAD) && !room && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.start) state_d = LOAD;
            LOAD:       if ((accept && bus.in_last) || overflow) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = room;
                cpu_hold = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Address and data hold their last value between writes; only we marks a valid write.
    always_comb begin
        we_d    = accept;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        if (session_start) begin
            count_d = '0;
            err_d   = 1'b0;
        end else if (accept) begin
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = enc_word;
            count_d = count_q + ONE_C;
            err_d   = err_q | enc_illegal | enc_range_err;
        end else if (overflow) begin
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.cpu_hold   = cpu_hold;
    assign bus.done       = done;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.count      = count_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader (DEPTH=4): scoreboard of expected imem writes plus status checks.
// Expected err for out-of-range immediates follows IMEM_RANGE_CHECK_EN.
module tb_imem_program_loader;
    import rv_encode_pkg::*;

`ifdef IMEM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] word;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   exp_cnt;
    int   we_run;
    int   max_run;
    exp_t sb[$];

    imem_program_loader_if #(.ADDR_W(5)) bus ();

    imem_program_loader #(.ADDR_W(5), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Write monitor: every imem write must match the oldest accepted beat, one cycle later.
    initial begin
        exp_t e;
        we_run  = 0;
        max_run = 0;
        forever begin
            @(negedge clk);
            if (bus.imem_we === 1'b1) begin
                we_run++;
                if (we_run > max_run) max_run = we_run;
                if (sb.size() == 0) begin
                    chk("spurious_write", 32'(bus.imem_addr), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("imem_addr", 32'(bus.imem_addr), 32'(e.addr));
                    chk("imem_wdata", bus.imem_wdata, e.word);
                    chk("write_latency", 32'(cyc), 32'(e.cyc + 1));
                end
            end else begin
                we_run = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic clears);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        if (clears) exp_cnt = 0;
    endtask

    task automatic beat(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [20:0] imm, input logic last,
                        input logic [31:0] w, input int budget, output logic acc);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_kind  = k;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
        bus.in_last  = last;
        acc = 1'b0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                acc    = 1'b1;
                e.addr = 5'(exp_cnt);
                e.word = w;
                e.cyc  = cyc;
                sb.push_back(e);
                exp_cnt++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic put(input string tag, input logic [2:0] k, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [20:0] imm,
                       input logic last, input logic [31:0] w);
        logic acc;
        beat(k, rd, rs1, rs2, imm, last, w, 20, acc);
        chk(tag, 32'(acc), 32'd1);
    endtask

    task automatic chk_status(input string tag, input logic d, input logic h,
                              input int c, input logic e);
        chk({tag, "_done"}, 32'(bus.done), 32'(d));
        chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'(h));
        chk({tag, "_count"}, 32'(bus.count), 32'(c));
        chk({tag, "_err"}, 32'(bus.err), 32'(e));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_we"}, 32'(bus.imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
        chk({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        chk_status(tag, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        logic acc;
        n_chk = 0; n_pass = 0; exp_cnt = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_kind = 3'd0; bus.in_rd = 5'd0;
        bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0; bus.in_imm = 21'd0; bus.in_last = 1'b0;
        step(3);
        rst = 1'b0;
        chk_reset("reset");

        // R-type trio then a load, back to back
        pulse_start(1'b1);
        chk("load_ready", 32'(bus.in_ready), 32'd1);
        chk_status("load", 1'b0, 1'b1, 0, 1'b0);
        put("acc_add", 3'(K_ADD), 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 32'h0020_81B3);
        put("acc_and", 3'(K_AND), 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 32'h0020_F1B3);
        put("acc_or",  3'(K_OR),  5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 32'h0020_E1B3);
        put("acc_lw",  3'(K_LW),  5'd5, 5'd1, 5'd0, 21'd8, 1'b1, 32'h0080_A283);
        step(2);
        chk_status("prog1", 1'b1, 1'b0, 4, 1'b0);

        // Store, branch, jump with valid held three cycles
        pulse_start(1'b1);
        max_run = 0;
        put("acc_sw",  3'(K_SW),  5'd0, 5'd1, 5'd2, 21'd12, 1'b0, 32'h0020_A623);
        put("acc_beq", 3'(K_BEQ), 5'd0, 5'd0, 5'd0, 21'h1F_FFFC, 1'b0, 32'hFE00_0EE3);
        put("acc_jal", 3'(K_JAL), 5'd1, 5'd0, 5'd0, 21'd0, 1'b1, 32'h0000_00EF);
        step(2);
        chk("b2b_run", 32'(max_run), 32'd3);
        chk_status("prog2", 1'b1, 1'b0, 3, 1'b0);

        // Overflow: fifth beat into a four-word imem is dropped
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++)
            put("acc_fill", 3'(K_ADD), 5'(i + 1), 5'd1, 5'd2, 21'd0, 1'b0,
                {7'b0, 5'd2, 5'd1, 3'b000, 5'(i + 1), 7'b0110011});
        @(negedge clk);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        beat(3'(K_OR), 5'd9, 5'd1, 5'd2, 21'd0, 1'b0, 32'h0, 3, acc);
        chk("overflow_dropped", 32'(acc), 32'd0);
        step(1);
        chk_status("ovf", 1'b1, 1'b0, 4, 1'b1);

        // Reserved kind writes a NOP and flags err
        pulse_start(1'b1);
        put("acc_rsvd", 3'(K_RSVD), 5'd7, 5'd7, 5'd7, 21'h1F_FFFF, 1'b1, NOP_WORD);
        step(2);
        chk_status("rsvd", 1'b1, 1'b0, 1, 1'b1);

        // Immediates outside their fields
        pulse_start(1'b1);
        put("acc_beq5", 3'(K_BEQ), 5'd0, 5'd0, 5'd0, 21'd5, 1'b1, 32'h0000_0263);
        step(2);
        chk_status("beq_range", 1'b1, 1'b0, 1, RC);
        pulse_start(1'b1);
        put("acc_lw2048", 3'(K_LW), 5'd5, 5'd1, 5'd0, 21'd2048, 1'b1, 32'h8000_A283);
        step(2);
        chk_status("lw_range", 1'b1, 1'b0, 1, RC);

        // start ignored mid-load, then reset mid-load
        pulse_start(1'b1);
        put("acc_m0", 3'(K_ADD), 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 32'h0020_81B3);
        put("acc_m1", 3'(K_OR),  5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 32'h0020_E1B3);
        pulse_start(1'b0);
        step(1);
        chk_status("start_in_load", 1'b0, 1'b1, 2, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_reset("midload_rst");

        step(2);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
